// File: rtl/multicycle_controller_pkg.sv
// Shared constants for the multicycle MIPS controller: opcodes, func codes,
// ALU operation codes, mux select codes, FSM states and per-state outputs.
package multicycle_controller_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;

  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_JUMP   = 2'd1;
  localparam logic [1:0] PCSRC_A      = 2'd2;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd3;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    R_EXEC   = 4'd2,
    R_WB     = 4'd3,
    MEM_ADDR = 4'd4,
    LW_READ  = 4'd5,
    LW_WB    = 4'd6,
    SW_WRITE = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    JAL      = 4'd10,
    JR       = 4'd11,
    I_EXEC   = 4'd12,
    I_WB     = 4'd13
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       jal_reg;
    logic       pc_to_reg;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic       i_or_d;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
  } ctrl_t;

  // ALU operation for the immediate arithmetic instructions
  function automatic logic [2:0] imm_alu_op(input logic [5:0] opcode);
    case (opcode)
      OP_SLTI: return ALU_SLT;
      OP_ANDI: return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  // Moore outputs of each state; the conditional branch write is added outside
  function automatic ctrl_t state_ctrl(input state_t s, input logic [2:0] r_op,
                                       input logic [2:0] i_op);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.pc_src    = PCSRC_ALU;
        c.pc_write  = 1'b1;
      end
      DECODE:   c.alu_src_b = SRCB_IMM_SH;
      R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_op    = r_op;
      end
      R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        c.alu_op    = r_op;
      end
      MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      LW_READ: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      LW_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      SW_WRITE: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_SUB;
        c.pc_src    = PCSRC_ALUOUT;
      end
      JUMP: begin
        c.pc_src   = PCSRC_JUMP;
        c.pc_write = 1'b1;
      end
      JAL: begin
        c.reg_write = 1'b1;
        c.jal_reg   = 1'b1;
        c.pc_to_reg = 1'b1;
        c.pc_src    = PCSRC_JUMP;
        c.pc_write  = 1'b1;
      end
      JR: begin
        c.pc_src   = PCSRC_A;
        c.pc_write = 1'b1;
      end
      I_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = i_op;
      end
      I_WB: begin
        c.reg_write = 1'b1;
        c.alu_op    = i_op;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_control.sv
// Maps the R-type func field onto the ALU operation code.
module alu_control
  import multicycle_controller_pkg::*;
(
  input  logic [5:0] func,
  output logic [2:0] alu_op
);

  // Unknown func codes fall back to ADD
  always_comb begin
    alu_op = ALU_ADD;
    case (func)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: Moore, registered outputs, with only the
// branch PC write following the live ALU zero flag.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic               ZERO,
  output logic               pc_write,
  output logic               IR_write,
  output logic               reg_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_dst,
  output logic               jal_reg,
  output logic               pc_to_reg,
  output logic               mem_to_reg,
  output logic               alu_src_A,
  output logic               I_or_D,
  output logic [1:0]         alu_src_B,
  output logic [1:0]         pc_src,
  output logic [2:0]         alu_op,
  output logic [STATE_W-1:0] state
);

  state_t     state_q;
  state_t     state_d;
  ctrl_t      ctrl_q;
  logic       branch_q;
  logic       bne_q;
  logic [2:0] r_op;
  logic [2:0] i_op;

  alu_control u_alu_control (
    .func   (func),
    .alu_op (r_op)
  );

  assign i_op = imm_alu_op(opcode);

  // Next-state decode; opcode/func are only consulted in states that need them
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_RTYPE:                  state_d = (func == FN_JR) ? JR : R_EXEC;
          OP_LW, OP_SW:              state_d = MEM_ADDR;
          OP_BEQ, OP_BNE:            state_d = BRANCH;
          OP_J:                      state_d = JUMP;
          OP_JAL:                    state_d = JAL;
          OP_ADDI, OP_SLTI, OP_ANDI: state_d = I_EXEC;
          default:                   state_d = FETCH;
        endcase
      end
      R_EXEC:   state_d = R_WB;
      MEM_ADDR: state_d = (opcode == OP_LW) ? LW_READ : SW_WRITE;
      LW_READ:  state_d = LW_WB;
      I_EXEC:   state_d = I_WB;
      default:  state_d = FETCH;
    endcase
  end

  // State and output registers; outputs are precomputed for the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FETCH;
      ctrl_q   <= state_ctrl(FETCH, ALU_ADD, ALU_ADD);
      branch_q <= 1'b0;
      bne_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= state_ctrl(state_d, r_op, i_op);
      branch_q <= (state_d == BRANCH);
      bne_q    <= (opcode == OP_BNE);
    end
  end

  assign pc_write   = ~rst & (ctrl_q.pc_write | (branch_q & (ZERO ^ bne_q)));
  assign IR_write   = ~rst & ctrl_q.ir_write;
  assign reg_write  = ~rst & ctrl_q.reg_write;
  assign mem_read   = ~rst & ctrl_q.mem_read;
  assign mem_write  = ~rst & ctrl_q.mem_write;
  assign reg_dst    = ~rst & ctrl_q.reg_dst;
  assign jal_reg    = ~rst & ctrl_q.jal_reg;
  assign pc_to_reg  = ~rst & ctrl_q.pc_to_reg;
  assign mem_to_reg = ~rst & ctrl_q.mem_to_reg;
  assign alu_src_A  = ~rst & ctrl_q.alu_src_a;
  assign I_or_D     = ~rst & ctrl_q.i_or_d;
  assign alu_src_B  = rst ? 2'b00 : ctrl_q.alu_src_b;
  assign pc_src     = rst ? 2'b00 : ctrl_q.pc_src;
  assign alu_op     = rst ? 3'b000 : ctrl_q.alu_op;
  assign state      = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for the multicycle controller plus
// hand-written reset and live-ZERO sequences.
module tb_multicycle_controller;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       ZERO;
  logic       pc_write, IR_write, reg_write, mem_read, mem_write;
  logic       reg_dst, jal_reg, pc_to_reg, mem_to_reg, alu_src_A, I_or_D;
  logic [1:0] alu_src_B;
  logic [1:0] pc_src;
  logic [2:0] alu_op;
  logic [3:0] state;
  logic [17:0] act;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_R_EXEC = 4'd2, S_R_WB = 4'd3;
  localparam logic [3:0] S_MEM_ADDR = 4'd4, S_LW_READ = 4'd5, S_LW_WB = 4'd6, S_SW_WRITE = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8, S_JUMP = 4'd9, S_JAL = 4'd10, S_JR = 4'd11;
  localparam logic [3:0] S_I_EXEC = 4'd12, S_I_WB = 4'd13;

  localparam logic [17:0] PCW   = 18'd1 << 17;
  localparam logic [17:0] IRW   = 18'd1 << 16;
  localparam logic [17:0] RW    = 18'd1 << 15;
  localparam logic [17:0] MRD   = 18'd1 << 14;
  localparam logic [17:0] MWR   = 18'd1 << 13;
  localparam logic [17:0] RDST  = 18'd1 << 12;
  localparam logic [17:0] JALR  = 18'd1 << 11;
  localparam logic [17:0] PTR   = 18'd1 << 10;
  localparam logic [17:0] MTR   = 18'd1 << 9;
  localparam logic [17:0] SA    = 18'd1 << 8;
  localparam logic [17:0] IOD   = 18'd1 << 7;
  localparam logic [17:0] SB4   = 18'd1 << 5;
  localparam logic [17:0] SBI   = 18'd2 << 5;
  localparam logic [17:0] SBS   = 18'd3 << 5;
  localparam logic [17:0] PSJ   = 18'd1 << 3;
  localparam logic [17:0] PSA   = 18'd2 << 3;
  localparam logic [17:0] PSO   = 18'd3 << 3;
  localparam logic [17:0] A_SUB = 18'd1;
  localparam logic [17:0] A_AND = 18'd2;
  localparam logic [17:0] A_OR  = 18'd3;
  localparam logic [17:0] A_SLT = 18'd4;
  localparam logic [17:0] F_O   = PCW | IRW | MRD | SB4;
  localparam logic [17:0] D_O   = SBS;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, J = 6'b000010, JALO = 6'b000011, ADDI = 6'b001000;
  localparam logic [5:0] SLTI = 6'b001010, ANDI = 6'b001100, ILL = 6'b111111;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        zero;
    logic [3:0]  st;
    logic [17:0] outs;
  } vec_t;

  vec_t vecs[$];

  multicycle_controller #(.STATE_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .func       (func),
    .ZERO       (ZERO),
    .pc_write   (pc_write),
    .IR_write   (IR_write),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_dst    (reg_dst),
    .jal_reg    (jal_reg),
    .pc_to_reg  (pc_to_reg),
    .mem_to_reg (mem_to_reg),
    .alu_src_A  (alu_src_A),
    .I_or_D     (I_or_D),
    .alu_src_B  (alu_src_B),
    .pc_src     (pc_src),
    .alu_op     (alu_op),
    .state      (state)
  );

  assign act = {pc_write, IR_write, reg_write, mem_read, mem_write, reg_dst, jal_reg,
                pc_to_reg, mem_to_reg, alu_src_A, I_or_D, alu_src_B, pc_src, alu_op};

  // Free-running clock, 10 ns period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic add_row(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                         input logic [3:0] st, input logic [17:0] outs);
    vec_t v;
    v.op = op; v.fn = fn; v.zero = zero; v.st = st; v.outs = outs;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic zero);
    opcode = op;
    func   = fn;
    ZERO   = zero;
  endtask

  task automatic checkOutput(input string tag, input int idx, input logic [3:0] exp_st,
                             input logic [17:0] exp_o);
    checks++;
    if (state !== exp_st) begin
      errors++;
      $display("[TB] FAIL %s[%0d] state: got %0d expected %0d", tag, idx, state, exp_st);
    end
    checks++;
    if (act !== exp_o) begin
      errors++;
      $display("[TB] FAIL %s[%0d] outputs: got %b expected %b", tag, idx, act, exp_o);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Main stimulus: reset, vector table, then the reset/ZERO corner sequences
  initial begin
    // add / sub / and / or / slt / unknown func
    add_row(RT, 6'b100000, 0, S_FETCH, F_O);   add_row(RT, 6'b100000, 0, S_DECODE, D_O);
    add_row(RT, 6'b100000, 1, S_R_EXEC, SA);   add_row(RT, 6'b100000, 1, S_R_WB, RW | RDST);
    add_row(RT, 6'b100010, 0, S_FETCH, F_O);   add_row(RT, 6'b100010, 0, S_DECODE, D_O);
    add_row(RT, 6'b100010, 0, S_R_EXEC, SA | A_SUB); add_row(RT, 6'b100010, 0, S_R_WB, RW | RDST | A_SUB);
    add_row(RT, 6'b100100, 0, S_FETCH, F_O);   add_row(RT, 6'b100100, 0, S_DECODE, D_O);
    add_row(RT, 6'b100100, 0, S_R_EXEC, SA | A_AND); add_row(RT, 6'b100100, 0, S_R_WB, RW | RDST | A_AND);
    add_row(RT, 6'b100101, 0, S_FETCH, F_O);   add_row(RT, 6'b100101, 0, S_DECODE, D_O);
    add_row(RT, 6'b100101, 0, S_R_EXEC, SA | A_OR);  add_row(RT, 6'b100101, 0, S_R_WB, RW | RDST | A_OR);
    add_row(RT, 6'b101010, 0, S_FETCH, F_O);   add_row(RT, 6'b101010, 0, S_DECODE, D_O);
    add_row(RT, 6'b101010, 0, S_R_EXEC, SA | A_SLT); add_row(RT, 6'b101010, 0, S_R_WB, RW | RDST | A_SLT);
    add_row(RT, 6'b000111, 0, S_FETCH, F_O);   add_row(RT, 6'b000111, 0, S_DECODE, D_O);
    add_row(RT, 6'b000111, 0, S_R_EXEC, SA);   add_row(RT, 6'b000111, 0, S_R_WB, RW | RDST);
    // lw then sw
    add_row(LW, 6'd0, 0, S_FETCH, F_O);        add_row(LW, 6'd0, 0, S_DECODE, D_O);
    add_row(LW, 6'd0, 0, S_MEM_ADDR, SA | SBI); add_row(LW, 6'd0, 0, S_LW_READ, MRD | IOD);
    add_row(LW, 6'd0, 0, S_LW_WB, RW | MTR);
    add_row(SW, 6'd0, 0, S_FETCH, F_O);        add_row(SW, 6'd0, 0, S_DECODE, D_O);
    add_row(SW, 6'd0, 0, S_MEM_ADDR, SA | SBI); add_row(SW, 6'd0, 0, S_SW_WRITE, MWR | IOD);
    // branches with both ZERO values
    add_row(BEQ, 6'd0, 1, S_FETCH, F_O);       add_row(BEQ, 6'd0, 1, S_DECODE, D_O);
    add_row(BEQ, 6'd0, 1, S_BRANCH, SA | A_SUB | PSO | PCW);
    add_row(BEQ, 6'd0, 0, S_FETCH, F_O);       add_row(BEQ, 6'd0, 0, S_DECODE, D_O);
    add_row(BEQ, 6'd0, 0, S_BRANCH, SA | A_SUB | PSO);
    add_row(BNE, 6'd0, 0, S_FETCH, F_O);       add_row(BNE, 6'd0, 0, S_DECODE, D_O);
    add_row(BNE, 6'd0, 0, S_BRANCH, SA | A_SUB | PSO | PCW);
    add_row(BNE, 6'd0, 1, S_FETCH, F_O);       add_row(BNE, 6'd0, 1, S_DECODE, D_O);
    add_row(BNE, 6'd0, 1, S_BRANCH, SA | A_SUB | PSO);
    // jumps
    add_row(J, 6'd0, 1, S_FETCH, F_O);         add_row(J, 6'd0, 1, S_DECODE, D_O);
    add_row(J, 6'd0, 1, S_JUMP, PSJ | PCW);
    add_row(JALO, 6'd0, 0, S_FETCH, F_O);      add_row(JALO, 6'd0, 0, S_DECODE, D_O);
    add_row(JALO, 6'd0, 0, S_JAL, RW | JALR | PTR | PSJ | PCW);
    add_row(RT, 6'b001000, 0, S_FETCH, F_O);   add_row(RT, 6'b001000, 0, S_DECODE, D_O);
    add_row(RT, 6'b001000, 0, S_JR, PSA | PCW);
    // illegal opcode returns straight to FETCH
    add_row(ILL, 6'd0, 1, S_FETCH, F_O);       add_row(ILL, 6'd0, 1, S_DECODE, D_O);
    // immediates
    add_row(ADDI, 6'd0, 0, S_FETCH, F_O);      add_row(ADDI, 6'd0, 0, S_DECODE, D_O);
    add_row(ADDI, 6'd0, 0, S_I_EXEC, SA | SBI); add_row(ADDI, 6'd0, 0, S_I_WB, RW);
    add_row(SLTI, 6'd0, 0, S_FETCH, F_O);      add_row(SLTI, 6'd0, 0, S_DECODE, D_O);
    add_row(SLTI, 6'd0, 0, S_I_EXEC, SA | SBI | A_SLT); add_row(SLTI, 6'd0, 0, S_I_WB, RW | A_SLT);
    add_row(ANDI, 6'd0, 0, S_FETCH, F_O);      add_row(ANDI, 6'd0, 0, S_DECODE, D_O);
    add_row(ANDI, 6'd0, 0, S_I_EXEC, SA | SBI | A_AND); add_row(ANDI, 6'd0, 0, S_I_WB, RW | A_AND);

    rst = 1'b1;
    applyStimulus(BEQ, 6'd0, 1'b1);
    #2;
    checkOutput("reset", 0, S_FETCH, 18'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("release", 0, S_FETCH, F_O);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].op, vecs[i].fn, vecs[i].zero);
      #2;
      checkOutput("vec", i, vecs[i].st, vecs[i].outs);
      step();
    end

    // Reset asserted in the middle of LW_READ aborts the read
    applyStimulus(LW, 6'd0, 1'b0);
    #1; checkOutput("lw_rst", 0, S_FETCH, F_O);
    step(); #1; checkOutput("lw_rst", 1, S_DECODE, D_O);
    step(); #1; checkOutput("lw_rst", 2, S_MEM_ADDR, SA | SBI);
    step(); #1; checkOutput("lw_rst", 3, S_LW_READ, MRD | IOD);
    rst = 1'b1;
    #1; checkOutput("lw_rst", 4, S_FETCH, 18'd0);
    step(); checkOutput("lw_rst", 5, S_FETCH, 18'd0);
    rst = 1'b0;
    #1; checkOutput("lw_rst", 6, S_FETCH, F_O);
    step(); #1; checkOutput("lw_rst", 7, S_DECODE, D_O);

    // Back to FETCH, then beq with ZERO changing inside BRANCH and a reset there
    rst = 1'b1; #1; rst = 1'b0; #1;
    applyStimulus(BEQ, 6'd0, 1'b1);
    #1; checkOutput("beq_live", 0, S_FETCH, F_O);
    step(); #1; checkOutput("beq_live", 1, S_DECODE, D_O);
    step(); #1; checkOutput("beq_live", 2, S_BRANCH, SA | A_SUB | PSO | PCW);
    ZERO = 1'b0;
    #1; checkOutput("beq_live", 3, S_BRANCH, SA | A_SUB | PSO);
    ZERO = 1'b1;
    #1; checkOutput("beq_live", 4, S_BRANCH, SA | A_SUB | PSO | PCW);
    rst = 1'b1;
    #1; checkOutput("beq_live", 5, S_FETCH, 18'd0);
    rst = 1'b0;
    #1; checkOutput("beq_live", 6, S_FETCH, F_O);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
